lectura_sensor: RTL and testbench
=================================

Name: lectura_sensor

Overview:
- Acquisition stage directly upstream of the system controller.
- While the controller asserts Enable_Sensar, the block reads a serial temperature sensor over a 3-wire SPI-like link (cs_n, sck, sdi).
- It averages 2^AVG_SHIFT consecutive conversions and presents the result on Temperatura.
- It then pulses Temp_En for one cycle, which moves the controller from its read state to its decide state.

Parameters:
- DATA_W, 12, bits per sensor conversion frame, MSB first.
- CLK_DIV, 4, clk cycles per sck half-period (>=1).
- AVG_SHIFT, 2, log2 of the number of conversions averaged (0 = no averaging).

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst  input  1  synchronous, active-low reset.
- Enable_Sensar  input  1  acquisition request from controller, level-sensitive.
- sdi  input  1  serial data from sensor.
- cs_n  output  1  sensor chip select, active low.
- sck  output  1  serial clock to sensor, idles low.
- Temperatura  output  DATA_W  averaged reading, held until next update.
- Temp_En  output  1  one-cycle pulse: new Temperatura valid.
- Ocupado  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; cs_n=1, sck=0, Temp_En=0, Ocupado=0, Temperatura=0; accumulator, divider, bit and sample counters cleared.
- Reset dominates every other input. Asserting it mid-frame aborts the frame immediately, with no Temp_En.
- All outputs are registered.
- States are IDLE, CS_SETUP, SHIFT, GAP, DONE.
- IDLE: cs_n=1, sck=0. Enable_Sensar=1 at a clk edge causes the following:
  - go to CS_SETUP;
  - clear the accumulator and sample counter.
- CS_SETUP: cs_n=0, sck=0 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: cs_n=0, sck toggles every CLK_DIV cycles, starting low. One bit spans 2*CLK_DIV cycles.
  - sdi is captured into the shift register on the clk edge where sck is driven 0->1.
  - After DATA_W rising sck edges and the final low half-period, add the DATA_W-bit frame to the accumulator, then go to GAP.
- GAP: cs_n=1, sck=0 for 2*CLK_DIV cycles. Then:
  - if the sample counter = 2^AVG_SHIFT-1, go to DONE;
  - else increment the sample counter and go to CS_SETUP.
- DONE (one cycle): Temperatura <= accumulator >> AVG_SHIFT (truncating), Temp_En=1, then go to IDLE.
- Accumulator width is DATA_W+AVG_SHIFT, so it never overflows.
- Latency: Temp_En is high in cycle 1 + 2^AVG_SHIFT*(3*CLK_DIV + 2*CLK_DIV*DATA_W) after the IDLE edge that sampled Enable_Sensar=1. With defaults this is cycle 433.
- Enable_Sensar deasserted mid-acquisition: the current frame completes through GAP, then the block returns to IDLE.
  - No Temp_En is issued.
  - Temperatura keeps its old value.
- Enable_Sensar still high after DONE: IDLE restarts on the next edge. Back-to-back acquisitions are legal.
- Temp_En is never high for more than one consecutive cycle.
- Temperatura changes only in the DONE cycle.

Test Plan:
- Reset: hold rst=0 for 3 cycles with Enable_Sensar=1 and sdi toggling -> cs_n=1, sck=0, Temp_En=0, Ocupado=0, Temperatura=0x000 throughout.
- Constant reading: the sensor model returns 0x190 for 4 frames -> Temperatura=0x190 and Temp_En pulses exactly at cycle 433 after enable. The bench checks 12 rising sck per frame and cs_n low for 100 cycles per frame.
- Averaging with truncation: frames 0x100, 0x101, 0x101, 0x101 -> sum 0x403, Temperatura=0x100.
- Extremes: 4 frames of 0xFFF -> Temperatura=0xFFF (no overflow). Then 4 frames of 0x000 on a back-to-back acquisition -> Temperatura=0x000 with a second Temp_En pulse.
- Abort: drop Enable_Sensar during frame 2 -> the frame finishes and GAP occurs. The block returns to IDLE with no Temp_En and Temperatura unchanged.
- Reset mid-SHIFT: rst=0 for 1 cycle at bit 5 of frame 1 -> cs_n=1 and sck=0 on the next edge. A new acquisition then runs correctly from the first frame.

Source files
------------

// File: rtl/lectura_sensor_if.sv
// Signal bundle between the temperature acquisition stage, the controller and the serial sensor.
// Enable_Sensar is a level request; Temp_En is a one-cycle strobe that qualifies Temperatura.
interface lectura_sensor_if #(
  parameter int DATA_W = 12
);
  logic              Enable_Sensar;
  logic              sdi;
  logic              cs_n;
  logic              sck;
  logic [DATA_W-1:0] Temperatura;
  logic              Temp_En;
  logic              Ocupado;

  modport master (
    output Enable_Sensar, sdi,
    input  cs_n, sck, Temperatura, Temp_En, Ocupado
  );

  modport slave (
    input  Enable_Sensar, sdi,
    output cs_n, sck, Temperatura, Temp_En, Ocupado
  );
endinterface

// File: rtl/lectura_sensor.sv
// Reads 2^AVG_SHIFT serial sensor frames, averages them and strobes Temp_En with the result.
// All outputs are registered; state_dbg mirrors the FSM state.
module lectura_sensor #(
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 4,
  parameter int AVG_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  lectura_sensor_if.slave        bus,
  output logic [2:0]             state_dbg
);
  localparam int ACC_W = DATA_W + AVG_SHIFT;
  localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam int SMP_W = AVG_SHIFT + 1;
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'((1 << AVG_SHIFT) - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, GAP, DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SMP_W-1:0]  sample;
  logic [DATA_W-1:0] shreg;
  logic [ACC_W-1:0]  acc;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      div             <= '0;
      bit_cnt         <= '0;
      sample          <= '0;
      shreg           <= '0;
      acc             <= '0;
      bus.cs_n        <= 1'b1;
      bus.sck         <= 1'b0;
      bus.Temperatura <= '0;
      bus.Temp_En     <= 1'b0;
      bus.Ocupado     <= 1'b0;
    end else begin
      bus.Temp_En <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Enable_Sensar) begin
            state       <= CS_SETUP;
            acc         <= '0;
            sample      <= '0;
            div         <= '0;
            bus.cs_n    <= 1'b0;
            bus.Ocupado <= 1'b1;
          end
        end
        // The setup interval doubles as the low half of the first bit, so the
        // first rising sck (and first sdi capture) happens on the way into SHIFT.
        CS_SETUP: begin
          if (div == HALF_LAST) begin
            state   <= SHIFT;
            div     <= '0;
            bit_cnt <= '0;
            bus.sck <= 1'b1;
            shreg   <= {shreg[DATA_W-2:0], bus.sdi};
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT: begin
          if (div != HALF_LAST) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            if (bus.sck) begin
              bus.sck <= 1'b0;
            end else if (bit_cnt == BIT_LAST) begin
              acc      <= acc + ACC_W'(shreg);
              state    <= GAP;
              bus.cs_n <= 1'b1;
            end else begin
              bus.sck <= 1'b1;
              shreg   <= {shreg[DATA_W-2:0], bus.sdi};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (div != GAP_LAST) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            if (!bus.Enable_Sensar) begin
              state       <= IDLE;
              bus.Ocupado <= 1'b0;
            end else if (sample == SMP_LAST) begin
              state           <= DONE;
              bus.Temperatura <= DATA_W'(acc >> AVG_SHIFT);
              bus.Temp_En     <= 1'b1;
            end else begin
              sample   <= sample + 1'b1;
              state    <= CS_SETUP;
              bus.cs_n <= 1'b0;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.Ocupado <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bus.cs_n    <= 1'b1;
          bus.sck     <= 1'b0;
          bus.Ocupado <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lectura_sensor.sv
// Bench for lectura_sensor: serial sensor model, directed acquisitions, expected-queue scoreboard.
module tb_lectura_sensor;
  localparam int DATA_W    = 12;
  localparam int CLK_DIV   = 4;
  localparam int AVG_SHIFT = 2;
  localparam int LATENCY   = 1 + (1 << AVG_SHIFT) * (3 * CLK_DIV + 2 * CLK_DIV * DATA_W);
  localparam int FRAME_CYC = 3 * CLK_DIV + 2 * CLK_DIV * DATA_W;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;

  lectura_sensor_if #(.DATA_W(DATA_W)) bus ();

  lectura_sensor #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .AVG_SHIFT(AVG_SHIFT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic frame_chk = 1'b1;

  logic [DATA_W-1:0] exp_q[$];
  int                cyc_q[$];
  logic [DATA_W-1:0] frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sensor model: MSB out when cs_n falls, next bit after each falling sck
  logic [DATA_W-1:0] cur;
  int   bit_i = 0;
  logic prev_cs = 1'b1;
  logic prev_sck = 1'b0;
  always @(negedge clk) begin
    if (bus.cs_n === 1'b0 && prev_cs) begin
      cur = '0;
      if (frame_q.size() > 0) cur = frame_q.pop_front();
      bit_i = DATA_W - 1;
      bus.sdi = cur[bit_i];
    end else if (bus.cs_n === 1'b0 && prev_sck && bus.sck === 1'b0) begin
      if (bit_i > 0) bit_i--;
      bus.sdi = cur[bit_i];
    end else if (bus.cs_n !== 1'b0) begin
      bus.sdi = 1'($urandom_range(0, 1));
    end
    prev_cs  = (bus.cs_n !== 1'b0);
    prev_sck = (bus.sck === 1'b1);
  end

  // monitor / scoreboard
  logic              prev_en = 1'b0;
  logic              prev_cs_m = 1'b1;
  logic              prev_sck_m = 1'b0;
  logic [DATA_W-1:0] prev_temp = '0;
  int                cs_low = 0;
  int                rises = 0;
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (bus.Temp_En === 1'b1) begin
      if (prev_en) check("temp_en_width", 32'(prev_en), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_temp_en", 32'(exp_q.size()), 32'd1);
      end else begin
        check("temperatura", 32'(bus.Temperatura), 32'(exp_q.pop_front()));
        check("temp_en_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
      end
    end else if (rst && bus.Temperatura !== prev_temp) begin
      check("temperatura_stable", 32'(bus.Temperatura), 32'(prev_temp));
    end
    if (bus.cs_n === 1'b0) begin
      cs_low++;
      if (bus.sck === 1'b1 && !prev_sck_m) rises++;
    end else if (!prev_cs_m) begin
      if (frame_chk) begin
        check("cs_low_cycles", 32'(cs_low), 32'd100);
        check("sck_rises", 32'(rises), 32'(DATA_W));
      end
      cs_low = 0;
      rises  = 0;
    end
    prev_en    = (bus.Temp_En === 1'b1);
    prev_cs_m  = (bus.cs_n !== 1'b0);
    prev_sck_m = (bus.sck === 1'b1);
    prev_temp  = bus.Temperatura;
  end

  // driver tasks
  task automatic wait_temp_en(input int limit);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.Temp_En !== 1'b1 && n < limit);
    if (bus.Temp_En !== 1'b1) check("temp_en_timeout", 32'(n), 32'(limit + 1));
  endtask

  task automatic run_acq(input logic [DATA_W-1:0] f0, f1, f2, f3, input logic [DATA_W-1:0] expv);
    @(negedge clk);
    frame_q.delete();
    frame_q.push_back(f0); frame_q.push_back(f1);
    frame_q.push_back(f2); frame_q.push_back(f3);
    exp_q.push_back(expv);
    cyc_q.push_back(cyc + LATENCY);
    bus.Enable_Sensar = 1'b1;
    wait_temp_en(1000);
    bus.Enable_Sensar = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, 32'(bus.cs_n), 32'd1);
    check({tag, "_sck"}, 32'(bus.sck), 32'd0);
    check({tag, "_temp_en"}, 32'(bus.Temp_En), 32'd0);
    check({tag, "_ocupado"}, 32'(bus.Ocupado), 32'd0);
    check({tag, "_temperatura"}, 32'(bus.Temperatura), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    rst = 1'b0;
    bus.Enable_Sensar = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_reset_outputs("reset");
    end
    @(negedge clk);
    rst = 1'b1;
    bus.Enable_Sensar = 1'b0;
    repeat (2) @(negedge clk);

    run_acq(12'h190, 12'h190, 12'h190, 12'h190, 12'h190);
    run_acq(12'h100, 12'h101, 12'h101, 12'h101, 12'h100);

    // abort during frame 2: frame and its gap complete, then idle with no strobe
    @(negedge clk);
    frame_q.delete();
    frame_q.push_back(12'h0AA); frame_q.push_back(12'h055);
    frame_q.push_back(12'h0AA); frame_q.push_back(12'h055);
    e0 = cyc + 1;
    bus.Enable_Sensar = 1'b1;
    repeat (160) @(negedge clk);
    bus.Enable_Sensar = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.Ocupado === 1'b1 && n < 400);
    check("abort_idle_cycle", 32'(cyc), 32'(e0 + 2 * FRAME_CYC));
    check("abort_cs_n", 32'(bus.cs_n), 32'd1);
    check("abort_temperatura", 32'(bus.Temperatura), 32'h100);
    repeat (20) @(negedge clk);
    check("abort_stays_idle", 32'(bus.Ocupado), 32'd0);

    // extremes back-to-back: 0xFFF then 0x000 with a second strobe
    @(negedge clk);
    frame_q.delete();
    repeat (4) frame_q.push_back(12'hFFF);
    repeat (4) frame_q.push_back(12'h000);
    exp_q.push_back(12'hFFF);
    cyc_q.push_back(cyc + LATENCY);
    exp_q.push_back(12'h000);
    cyc_q.push_back(cyc + LATENCY + LATENCY + 1);
    bus.Enable_Sensar = 1'b1;
    wait_temp_en(1000);
    wait_temp_en(1000);
    bus.Enable_Sensar = 1'b0;
    repeat (3) @(negedge clk);

    // reset at bit 5 of frame 1, then a clean acquisition restarts
    @(negedge clk);
    frame_q.delete();
    frame_q.push_back(12'h5A5);
    frame_chk = 1'b0;
    bus.Enable_Sensar = 1'b1;
    repeat (45) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    frame_q.delete();
    frame_q.push_back(12'h3C5); frame_q.push_back(12'h3C6);
    frame_q.push_back(12'h3C7); frame_q.push_back(12'h3C8);
    exp_q.push_back(12'h3C6);
    cyc_q.push_back(cyc + LATENCY);
    frame_chk = 1'b1;
    wait_temp_en(1000);
    bus.Enable_Sensar = 1'b0;
    repeat (5) @(negedge clk);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
